// File: rtl/axil_cmd_master.sv
// AXI4-Lite command master: turns 64-bit command words into single AXI4-Lite
// read or write transactions and returns {resp, rdata} on a response stream.
// Only one transaction is outstanding at any time.
module axil_cmd_master #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 11,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [63:0]                   S_AXIS_CMD_TDATA,
    input  logic                          S_AXIS_CMD_TVALID,
    output logic                          S_AXIS_CMD_TREADY,

    output logic [33:0]                   M_AXIS_RSP_TDATA,
    output logic                          M_AXIS_RSP_TVALID,
    input  logic                          M_AXIS_RSP_TREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,

    output logic [15:0]                   err_count
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWresp,
        StRead,
        StRdata,
        StRsp
    } state_e;

    state_e          state_q, state_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            rnw_q, rnw_d;
    logic [33:0]     rsp_q, rsp_d;
    logic [15:0]     err_count_q, err_count_d;

    logic            cmd_fire;
    logic            aw_fire;
    logic            w_fire;
    logic            rsp_latch;

    // Only the decoded fields are used; the rest of the command word is ignored.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^S_AXIS_CMD_TDATA;

    // Handshake outputs are decoded from registered state only, so reset clears them at once.
    always_comb begin
        S_AXIS_CMD_TREADY = cmd_ready_q;
        M_AXI_AWVALID     = (state_q == StWrite) && !aw_done_q;
        M_AXI_WVALID      = (state_q == StWrite) && !w_done_q;
        M_AXI_BREADY      = (state_q == StWresp);
        M_AXI_ARVALID     = (state_q == StRead);
        M_AXI_RREADY      = (state_q == StRdata);
        M_AXIS_RSP_TVALID = (state_q == StRsp);
        M_AXI_AWADDR      = addr_q;
        M_AXI_ARADDR      = addr_q;
        M_AXI_WDATA       = wdata_q;
        M_AXI_WSTRB       = wstrb_q;
        M_AXIS_RSP_TDATA  = rsp_q;
        err_count         = err_count_q;
    end

    assign cmd_fire = S_AXIS_CMD_TVALID && cmd_ready_q;
    assign aw_fire  = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_fire   = M_AXI_WVALID && M_AXI_WREADY;

    // Next-state, command capture, response latch and error counting.
    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rnw_d       = rnw_q;
        rsp_d       = rsp_q;
        err_count_d = err_count_q;
        rsp_latch   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    addr_d    = S_AXIS_CMD_TDATA[32 +: AW];
                    wdata_d   = S_AXIS_CMD_TDATA[DW-1:0];
                    wstrb_d   = S_AXIS_CMD_TDATA[59:56];
                    rnw_d     = S_AXIS_CMD_TDATA[63];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_AXIS_CMD_TDATA[63] ? StRead : StWrite;
                end
            end
            StWrite: begin
                // AW and W complete independently, in either order or together.
                if (aw_fire) aw_done_d = 1'b1;
                if (w_fire)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = StWresp;
                end
            end
            StWresp: begin
                if (M_AXI_BVALID) begin
                    rsp_latch = 1'b1;
                    state_d   = StRsp;
                end
            end
            StRead: begin
                if (M_AXI_ARREADY) state_d = StRdata;
            end
            StRdata: begin
                if (M_AXI_RVALID) begin
                    rsp_latch = 1'b1;
                    state_d   = StRsp;
                end
            end
            StRsp: begin
                if (M_AXIS_RSP_TREADY) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (rsp_latch) begin
            rsp_d = rnw_q ? {M_AXI_RRESP, M_AXI_RDATA} : {M_AXI_BRESP, {DW{1'b0}}};
            if ((rsp_d[33:32] != 2'b00) && (err_count_q != 16'hFFFF)) begin
                err_count_d = err_count_q + 16'd1;
            end
        end

        // Registered ready: low during reset, high on the first edge after it.
        cmd_ready_d = (state_d == StIdle);
    end

    // State and handshake-tracking registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
        end
    end

    // Captured command fields, latched response and error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rnw_q       <= 1'b0;
            rsp_q       <= '0;
            err_count_q <= '0;
        end else begin
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rnw_q       <= rnw_d;
            rsp_q       <= rsp_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 11, AXI4-Lite address width (1..24).
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (fixed 32).
REQ-003 SHALL have a single clock `clk` and an asynchronous, active-high reset `rst`, as follows:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous assert, active-high reset.
REQ-004 SHALL have the following command and response stream ports:
- S_AXIS_CMD_TDATA  in  64  command word; fields defined in REQ-005.
- S_AXIS_CMD_TVALID  in  1  command valid.
- S_AXIS_CMD_TREADY  out  1  command accepted.
- M_AXIS_RSP_TDATA  out  34  response word: [31:0] rdata, [33:32] resp.
- M_AXIS_RSP_TVALID  out  1  response valid.
- M_AXIS_RSP_TREADY  in  1  response consumed.
REQ-005 SHALL have the following AXI4-Lite master write ports:
- M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH  write address.
- M_AXI_AWVALID / M_AXI_AWREADY  out / in  1  write address handshake.
- M_AXI_WDATA  out  32  write data.
- M_AXI_WSTRB  out  4  byte strobes.
- M_AXI_WVALID / M_AXI_WREADY  out / in  1  write data handshake.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID / M_AXI_BREADY  in / out  1  write response handshake.
REQ-006 SHALL have the following AXI4-Lite master read ports and status output:
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  read address.
- M_AXI_ARVALID / M_AXI_ARREADY  out / in  1  read address handshake.
- M_AXI_RDATA  in  32  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RVALID / M_AXI_RREADY  in / out  1  read data handshake.
- err_count  out  16  saturating count of non-OKAY responses.

Function
REQ-007 SHALL decode the command word as: [31:0] wdata; [32+C_M_AXI_ADDR_WIDTH-1:32] addr; [59:56] wstrb; [63] rnw (1 = read); all other bits ignored.
REQ-008 SHALL implement FSM states IDLE, WRITE, WRESP, READ, RDATA, RSP.
REQ-009 SHALL assert S_AXIS_CMD_TREADY only in IDLE, and capture addr, wdata, wstrb and rnw into registers on the TVALID&TREADY cycle.
REQ-010 SHALL transition IDLE->WRITE on an accepted command with rnw=0 and IDLE->READ on rnw=1, asserting the corresponding VALIDs on the next cycle.
REQ-011 SHALL, in WRITE:
- assert AWVALID and WVALID together;
- drop each VALID independently after its own handshake;
- go to WRESP once both handshakes have completed, including when both complete in the same cycle or in either order.
REQ-012 SHALL, in WRESP, hold BREADY=1; on BVALID, latch {BRESP, 32'h0} and go to RSP.
REQ-013 SHALL, in READ, hold ARVALID until ARREADY, then go to RDATA.
REQ-014 SHALL, in RDATA, hold RREADY=1; on RVALID, latch {RRESP, RDATA} and go to RSP.
REQ-015 SHALL keep BREADY/RREADY low outside WRESP/RDATA, and SHALL NOT drop AWVALID, WVALID or ARVALID before their handshake.
REQ-016 SHALL hold AW/W/AR address and data outputs stable while the corresponding VALID is high.
REQ-017 SHALL, in RSP, assert M_AXIS_RSP_TVALID with stable TDATA until TREADY, then return to IDLE on the next cycle; only one transaction SHALL be outstanding.
REQ-018 SHALL make minimum latency from command accept to RSP_TVALID 3 cycles, given AXI slave ready/valid already high.
REQ-019 SHALL increment err_count by 1 when a latched resp is not 2'b00, and saturate it at 16'hFFFF without wrapping.

Reset
REQ-020 SHALL, while rst=1, asynchronously force:
- FSM to IDLE;
- all VALID/READY outputs to 0;
- AWADDR, ARADDR, WDATA, WSTRB, RSP_TDATA to 0;
- err_count to 0.
REQ-021 SHALL assert S_AXIS_CMD_TREADY=1 on the first clock edge after rst deasserts.
REQ-022 SHALL, on reset mid-transaction, abandon the transaction with no response emitted, and SHALL accept any late BVALID/RVALID arriving in IDLE without a state change.

Verification
REQ-023 SHALL be verified with these directed scenarios:
- Write cmd {rnw=0, wstrb=F, addr=0x004, wdata=0xDEADBEEF}, slave ready always -> one AW/W handshake; response 34'h0_00000000 three cycles after accept; err_count=0.
- Read cmd addr=0x008, slave returns RDATA=0x12345678, RRESP=0 -> response 0x0_12345678; no AW/W activity.
- Write with WREADY 5 cycles after AWREADY -> AWVALID drops after its handshake, WVALID held 5 cycles, exactly one B handshake.
- Read returning RRESP=2'b10 with M_AXIS_RSP_TREADY low 4 cycles -> TDATA stable at 0x2_xxxxxxxx for 4 cycles; err_count=1; CMD_TREADY low until response consumed.
- 65540 SLVERR reads -> err_count=16'hFFFF.
- rst pulsed during WRESP -> all VALIDs 0 immediately; no response; next command completes normally.
